ctrl_pipe_unit: RTL
===================

// Module: ctrl_pipe_unit
// PURPOSE
//  Second-generation control unit: decodes the 4-bit opcode (opcodes.vh encoding) in ID and carries
//  the control bundle through registered ID/EX, EX/MEM and MEM/WB stages. Generalised register-address width,
//  load-use stall, wrong-path flush, global freeze and halt tracking. Sits beside the datapath;
//  drives per-stage enables, replacing the purely combinational decoder.
// PARAMETERS
//  REG_W  4  register-address width; R0 is hardwired zero, never a hazard source/destination
//  OP_W   4  opcode width; decode compares only the opcodes.vh codes, others decode as NOP
// PORTS
//  clk            in   1      clock
//  rst_n          in   1      synchronous active-low reset
//  id_valid       in   1      instruction in ID is real
//  id_opcode      in   OP_W   opcode in ID
//  id_rs,id_rt,id_rd in REG_W register fields of the ID instruction
//  stall_in       in   1      freeze whole unit (memory wait)
//  flush          in   1      squash the instruction currently in ID (branch taken)
//  stall_out      out  1      combinational: hold PC and IF/ID this cycle
//  ex_valid,ex_alu_src,ex_mem_to_reg,ex_mem_wr,ex_branch,ex_reg_wren  out 1  EX-stage controls
//  ex_dst         out  REG_W  EX destination register
//  mem_valid,mem_mem_to_reg,mem_mem_wr,mem_reg_wren  out 1  MEM-stage controls; mem_dst out REG_W
//  wb_valid,wb_mem_to_reg,wb_reg_wren  out 1  WB-stage controls; wb_dst out REG_W
//  halted         out  1      sticky: HLT has reached WB
// BEHAVIOUR
//  - Decode: branch=B|BR; mem_to_reg=LW; mem_wr=SW; alu_src=LW|SW|ROR|SLL|SRA|LLB|LHB;
//    reg_wren=~op[3]|LW|LLB|LHB|PCS; dst=LW?rt:rd; halt=HLT.
//  - Source use: rs_used=~op[3]|LW|SW|BR; rt_used=ADD|SUB|XOR|RED|PADDSB|SW.
//  - All stage outputs registered; ID->EX latency 1 cycle, EX->MEM 1, MEM->WB 1.
//  - Bubble = valid 0 and every control bit 0 and dst 0; gated reg_wren/mem_wr never fire on bubbles.
//  - Reset (rst_n=0 at clk edge): all stage outputs 0, halted 0; stall_out 0 while rst_n=0.
//  - Per-cycle priority: reset > stall_in > flush > load-use stall > advance.
//  - stall_in=1: every stage register holds; stall_out=1; flush and load-use ignored that cycle.
//  - flush=1: EX loads bubble, MEM<-EX, WB<-MEM; stall_out=0 (flush overrides load-use).
//  - load-use: ex_valid & ex_mem_to_reg & ex_dst!=0 & id_valid & ((rs_used & id_rs==ex_dst) |
//    (rt_used & id_rt==ex_dst)) -> stall_out=1, EX loads bubble, MEM/WB advance; next cycle
//    the LW is in MEM, hazard clears, ID instruction enters EX (exactly one bubble).
//  - id_valid=0 -> EX loads bubble regardless of opcode.
//  - Halt: halt bit travels with the bundle; wb_valid & wb_halt sets halted on that edge.
//    While halted=1, ID is treated as id_valid=0; in-flight older stages still drain; halted
//    clears only on reset.
//  - Reset mid-stall or mid-flush: reset wins, no residual stall on release.
// CONFIGURATION
//  CTRL_LOAD_USE_STALL_EN defined: internal load-use detection as above.
//  Not defined: no load-use detection; stall_out = stall_in only; datapath must insert NOPs.
// TESTING
//  1 Reset: rst_n=0 two cycles with id_valid=1 ADD -> all outputs 0, halted 0; release -> ADD in EX next edge.
//  2 ADD R3,R1,R2 (op 0x0) then LW (0x8) R4: ex_reg_wren=1 ex_dst=3, then ex_mem_to_reg=1 ex_alu_src=1 ex_dst=4,
//    ADD reaches wb_valid=1 wb_dst=3 three edges after ID.
//  3 LW R5 in EX, ID=ADD R6,R5,R1 -> stall_out=1 one cycle, one bubble in EX, ADD enters EX next
//    cycle (EN build); same with ex_dst=R0 -> no stall.
//  4 flush=1 with SW (0x9) in ID -> ex_valid=0 ex_mem_wr=0 next edge; MEM/WB still advance.
//  5 stall_in=1 for 3 cycles with LW/ADD/SUB in EX/MEM/WB -> all outputs unchanged, stall_out=1; resume intact.
//  6 HLT (0xF) in ID, then ADDs -> halted rises the edge HLT is in WB+1; later ADDs become bubbles;
//    rst_n=0 clears halted.

Source files
------------

// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit: decodes the ID opcode and carries the control bundle through EX, MEM and WB.
// Optional feature macro: CTRL_LOAD_USE_STALL_EN enables internal load-use hazard detection.
module ctrl_pipe_unit #(
    parameter int REG_W = 4,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [OP_W-1:0]  id_opcode,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             stall_in,
    input  logic             flush,
    output logic             stall_out,
    output logic             ex_valid,
    output logic             ex_alu_src,
    output logic             ex_mem_to_reg,
    output logic             ex_mem_wr,
    output logic             ex_branch,
    output logic             ex_reg_wren,
    output logic [REG_W-1:0] ex_dst,
    output logic             mem_valid,
    output logic             mem_mem_to_reg,
    output logic             mem_mem_wr,
    output logic             mem_reg_wren,
    output logic [REG_W-1:0] mem_dst,
    output logic             wb_valid,
    output logic             wb_mem_to_reg,
    output logic             wb_reg_wren,
    output logic [REG_W-1:0] wb_dst,
    output logic             halted
);

    localparam logic [OP_W-1:0] OP_ADD    = OP_W'(4'h0);
    localparam logic [OP_W-1:0] OP_SUB    = OP_W'(4'h1);
    localparam logic [OP_W-1:0] OP_XOR    = OP_W'(4'h2);
    localparam logic [OP_W-1:0] OP_RED    = OP_W'(4'h3);
    localparam logic [OP_W-1:0] OP_SLL    = OP_W'(4'h4);
    localparam logic [OP_W-1:0] OP_SRA    = OP_W'(4'h5);
    localparam logic [OP_W-1:0] OP_ROR    = OP_W'(4'h6);
    localparam logic [OP_W-1:0] OP_PADDSB = OP_W'(4'h7);
    localparam logic [OP_W-1:0] OP_LW     = OP_W'(4'h8);
    localparam logic [OP_W-1:0] OP_SW     = OP_W'(4'h9);
    localparam logic [OP_W-1:0] OP_LHB    = OP_W'(4'hA);
    localparam logic [OP_W-1:0] OP_LLB    = OP_W'(4'hB);
    localparam logic [OP_W-1:0] OP_B      = OP_W'(4'hC);
    localparam logic [OP_W-1:0] OP_BR     = OP_W'(4'hD);
    localparam logic [OP_W-1:0] OP_PCS    = OP_W'(4'hE);
    localparam logic [OP_W-1:0] OP_HLT    = OP_W'(4'hF);

    logic             dec_alu_class;
    logic             dec_alu_src;
    logic             dec_mem_to_reg;
    logic             dec_mem_wr;
    logic             dec_branch;
    logic             dec_reg_wren;
    logic             dec_halt;
    logic [REG_W-1:0] dec_dst;

    logic             id_live;
    logic             load_use;
    logic             ex_bubble;

    logic             ex_halt;
    logic             mem_halt;
    logic             wb_halt;

    // ID decode: unknown opcodes leave every control bit low.
    always_comb begin
        dec_alu_class  = id_opcode inside {OP_ADD, OP_SUB, OP_XOR, OP_RED,
                                           OP_SLL, OP_SRA, OP_ROR, OP_PADDSB};
        dec_branch     = (id_opcode == OP_B) || (id_opcode == OP_BR);
        dec_mem_to_reg = (id_opcode == OP_LW);
        dec_mem_wr     = (id_opcode == OP_SW);
        dec_alu_src    = id_opcode inside {OP_LW, OP_SW, OP_ROR, OP_SLL,
                                           OP_SRA, OP_LLB, OP_LHB};
        dec_reg_wren   = dec_alu_class || (id_opcode inside {OP_LW, OP_LLB, OP_LHB, OP_PCS});
        dec_dst        = (id_opcode == OP_LW) ? id_rt : id_rd;
        dec_halt       = (id_opcode == OP_HLT);
    end

    // Once halted, nothing new is admitted from ID; older stages keep draining.
    assign id_live = id_valid && !halted;

`ifdef CTRL_LOAD_USE_STALL_EN
    logic rs_used;
    logic rt_used;

    always_comb begin
        rs_used = dec_alu_class || (id_opcode inside {OP_LW, OP_SW, OP_BR});
        rt_used = id_opcode inside {OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB, OP_SW};
    end

    // R0 never creates a dependency, so a load targeting it needs no stall.
    assign load_use = ex_valid && ex_mem_to_reg && (ex_dst != '0) && id_live &&
                      ((rs_used && (id_rs == ex_dst)) || (rt_used && (id_rt == ex_dst)));
    assign stall_out = rst_n && (stall_in || (!flush && load_use));
`else
    logic unused_fields;

    assign unused_fields = ^{id_rs, id_rt};
    assign load_use      = 1'b0;
    assign stall_out     = rst_n && stall_in;
`endif

    assign ex_bubble = flush || load_use || !id_live;

    // ID -> EX, EX -> MEM, MEM -> WB stage registers; stall_in freezes all three.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid       <= 1'b0;
            ex_alu_src     <= 1'b0;
            ex_mem_to_reg  <= 1'b0;
            ex_mem_wr      <= 1'b0;
            ex_branch      <= 1'b0;
            ex_reg_wren    <= 1'b0;
            ex_dst         <= '0;
            ex_halt        <= 1'b0;
            mem_valid      <= 1'b0;
            mem_mem_to_reg <= 1'b0;
            mem_mem_wr     <= 1'b0;
            mem_reg_wren   <= 1'b0;
            mem_dst        <= '0;
            mem_halt       <= 1'b0;
            wb_valid       <= 1'b0;
            wb_mem_to_reg  <= 1'b0;
            wb_reg_wren    <= 1'b0;
            wb_dst         <= '0;
            wb_halt        <= 1'b0;
        end else if (!stall_in) begin
            if (ex_bubble) begin
                ex_valid      <= 1'b0;
                ex_alu_src    <= 1'b0;
                ex_mem_to_reg <= 1'b0;
                ex_mem_wr     <= 1'b0;
                ex_branch     <= 1'b0;
                ex_reg_wren   <= 1'b0;
                ex_dst        <= '0;
                ex_halt       <= 1'b0;
            end else begin
                ex_valid      <= 1'b1;
                ex_alu_src    <= dec_alu_src;
                ex_mem_to_reg <= dec_mem_to_reg;
                ex_mem_wr     <= dec_mem_wr;
                ex_branch     <= dec_branch;
                ex_reg_wren   <= dec_reg_wren;
                ex_dst        <= dec_dst;
                ex_halt       <= dec_halt;
            end

            mem_valid      <= ex_valid;
            mem_mem_to_reg <= ex_mem_to_reg;
            mem_mem_wr     <= ex_mem_wr;
            mem_reg_wren   <= ex_reg_wren;
            mem_dst        <= ex_dst;
            mem_halt       <= ex_halt;

            wb_valid       <= mem_valid;
            wb_mem_to_reg  <= mem_mem_to_reg;
            wb_reg_wren    <= mem_reg_wren;
            wb_dst         <= mem_dst;
            wb_halt        <= mem_halt;
        end
    end

    // Sticky halt flag: set the edge after HLT occupies WB, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            halted <= 1'b0;
        end else if (wb_valid && wb_halt) begin
            halted <= 1'b1;
        end
    end

endmodule
